// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO feeding the IF/ID latch: circular buffer of {instr, pc, pc4, pred}
// with STALL hold, FLUSH clear and combinational head presentation (no bypass).
module fetch_queue #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              STALL,
  input  logic              Instr_Valid_IN,
  input  logic [31:0]       Instr_IN,
  input  logic [31:0]       Instr_PC_IN,
  input  logic [31:0]       Instr_PC_Plus4_IN,
  input  logic              Branch_prediction_IN,
  output logic              Queue_Full_OUT,
  output logic              Instr_Valid_OUT,
  output logic [31:0]       Instr1_OUT,
  output logic [31:0]       Instr_PC_OUT,
  output logic [31:0]       Instr_PC_Plus4_OUT,
  output logic              Branch_prediction_OUT,
  output logic [CNT_W-1:0]  Occupancy_OUT
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred;
  } entry_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t            mem_q [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop, push, wr_en;

  always_comb begin
    pop      = !STALL && (count_q != '0);
    push     = Instr_Valid_IN && ((count_q != FULL_CNT) || pop);
    wr_en    = push && !FLUSH;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Simultaneous push and pop leaves the count untouched.
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= '{instr: Instr_IN, pc: Instr_PC_IN,
                           pc4: Instr_PC_Plus4_IN, pred: Branch_prediction_IN};
    end
  end

  always_comb begin
    head = '0;
    if (count_q != '0) head = mem_q[rd_ptr_q];
    Instr_Valid_OUT       = (count_q != '0);
    Queue_Full_OUT        = (count_q == FULL_CNT);
    Occupancy_OUT         = count_q;
    Instr1_OUT            = head.instr;
    Instr_PC_OUT          = head.pc;
    Instr_PC_Plus4_OUT    = head.pc4;
    Branch_prediction_OUT = head.pred;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        FLUSH = 1'b0;
  logic        STALL = 1'b0;
  logic        Instr_Valid_IN = 1'b0;
  logic [31:0] Instr_IN = '0;
  logic [31:0] Instr_PC_IN = '0;
  logic [31:0] Instr_PC_Plus4_IN = '0;
  logic        Branch_prediction_IN = 1'b0;
  logic        Queue_Full_OUT;
  logic        Instr_Valid_OUT;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;
  logic        Branch_prediction_OUT;
  logic [2:0]  Occupancy_OUT;
  logic [101:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fetch_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL),
    .Instr_Valid_IN(Instr_Valid_IN), .Instr_IN(Instr_IN),
    .Instr_PC_IN(Instr_PC_IN), .Instr_PC_Plus4_IN(Instr_PC_Plus4_IN),
    .Branch_prediction_IN(Branch_prediction_IN),
    .Queue_Full_OUT(Queue_Full_OUT), .Instr_Valid_OUT(Instr_Valid_OUT),
    .Instr1_OUT(Instr1_OUT), .Instr_PC_OUT(Instr_PC_OUT),
    .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
    .Branch_prediction_OUT(Branch_prediction_OUT),
    .Occupancy_OUT(Occupancy_OUT)
  );

  assign obs = {Instr_Valid_OUT, Queue_Full_OUT, Occupancy_OUT, Instr1_OUT,
                Instr_PC_OUT, Instr_PC_Plus4_OUT, Branch_prediction_OUT};

  // Entry k: instr 0x2000_0000 | (k+1)<<16 | (k+1), pc 0x00400000 + 4k.
  function automatic logic [31:0] instr_of(int k);
    logic [31:0] n;
    n = 32'(k + 1);
    return 32'h2000_0000 | (n << 16) | n;
  endfunction

  function automatic logic [31:0] pc_of(int k);
    return 32'h0040_0000 + 32'(4 * k);
  endfunction

  function automatic logic [101:0] exp_head(int k, logic pred, logic [2:0] occ);
    return {1'b1, (occ == 3'd4), occ, instr_of(k), pc_of(k), pc_of(k) + 32'd4, pred};
  endfunction

  task automatic drive(logic v, int k, logic pred);
    Instr_Valid_IN       = v;
    Instr_IN             = instr_of(k);
    Instr_PC_IN          = pc_of(k);
    Instr_PC_Plus4_IN    = pc_of(k) + 32'd4;
    Branch_prediction_IN = pred;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_hold: got %h expected 0", obs);
    end
    RESET = 1'b1;
    tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_release: got %h expected 0", obs);
    end
    STALL = 1'b1;
    for (int k = 0; k < 3; k++) begin drive(1'b1, k, 1'b0); tick(); end
    drive(1'b0, 0, 1'b0);
    checks++;
    if (obs !== exp_head(0, 1'b0, 3'd3)) begin
      errors++; $display("FAIL reset_prefill: got %h expected %h", obs, exp_head(0, 1'b0, 3'd3));
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", obs);
    end
    tick();
    RESET = 1'b1;
    STALL = 1'b0;
    tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_after: got %h expected 0", obs);
    end
  endtask

  task automatic test_in_order();
    STALL = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, k, 1'b0);
      tick();
      checks++;
      if (obs !== exp_head(k, 1'b0, 3'd1)) begin
        errors++; $display("FAIL in_order_%0d: got %h expected %h", k, obs, exp_head(k, 1'b0, 3'd1));
      end
    end
    drive(1'b0, 0, 1'b0);
    tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL in_order_empty: got %h expected 0", obs);
    end
  endtask

  task automatic test_stall_full();
    logic [2:0] occ;
    STALL = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, k, 1'b0);
      tick();
      occ = (k < 4) ? 3'(k + 1) : 3'd4;
      checks++;
      if (obs !== exp_head(0, 1'b0, occ)) begin
        errors++; $display("FAIL stall_push_%0d: got %h expected %h", k, obs, exp_head(0, 1'b0, occ));
      end
    end
    drive(1'b0, 0, 1'b0);
    tick();
    checks++;
    if (obs !== exp_head(0, 1'b0, 3'd4)) begin
      errors++; $display("FAIL stall_hold: got %h expected %h", obs, exp_head(0, 1'b0, 3'd4));
    end
    STALL = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== exp_head(k, 1'b0, 3'(4 - k))) begin
        errors++; $display("FAIL stall_drain_%0d: got %h expected %h", k, obs, exp_head(k, 1'b0, 3'(4 - k)));
      end
    end
    tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL stall_empty: got %h expected 0", obs);
    end
  endtask

  task automatic test_full_push_pop();
    STALL = 1'b1;
    for (int k = 0; k < 4; k++) begin drive(1'b1, k, 1'b0); tick(); end
    drive(1'b0, 0, 1'b0);
    checks++;
    if (obs !== exp_head(0, 1'b0, 3'd4)) begin
      errors++; $display("FAIL fpp_full: got %h expected %h", obs, exp_head(0, 1'b0, 3'd4));
    end
    STALL = 1'b0;
    drive(1'b1, 4, 1'b0);
    tick();
    checks++;
    if (obs !== exp_head(1, 1'b0, 3'd4)) begin
      errors++; $display("FAIL fpp_pushpop: got %h expected %h", obs, exp_head(1, 1'b0, 3'd4));
    end
    drive(1'b0, 0, 1'b0);
    for (int k = 2; k < 5; k++) begin
      tick();
      checks++;
      if (obs !== exp_head(k, 1'b0, 3'(5 - k))) begin
        errors++; $display("FAIL fpp_drain_%0d: got %h expected %h", k, obs, exp_head(k, 1'b0, 3'(5 - k)));
      end
    end
    tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL fpp_empty: got %h expected 0", obs);
    end
  endtask

  task automatic test_flush();
    STALL = 1'b1;
    for (int k = 0; k < 3; k++) begin drive(1'b1, k, 1'b0); tick(); end
    checks++;
    if (obs !== exp_head(0, 1'b0, 3'd3)) begin
      errors++; $display("FAIL flush_prefill: got %h expected %h", obs, exp_head(0, 1'b0, 3'd3));
    end
    drive(1'b1, 8, 1'b1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    drive(1'b0, 0, 1'b0);
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL flush_clear: got %h expected 0", obs);
    end
    STALL = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL flush_discard: got %h expected 0", obs);
    end
  endtask

  task automatic test_back_to_back();
    logic pred;
    STALL = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pred = ((k % 2) == 0);
      drive(1'b1, k, pred);
      tick();
      checks++;
      if (obs !== exp_head(k, pred, 3'd1)) begin
        errors++; $display("FAIL b2b_%0d: got %h expected %h", k, obs, exp_head(k, pred, 3'd1));
      end
    end
    drive(1'b0, 0, 1'b0);
    tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL b2b_empty: got %h expected 0", obs);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_stall_full();
    test_full_push_pop();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction prefetch buffer on the producer side of the IF/ID pipeline latch. Accepts fetched instructions from the fetch unit and stores PC, PC+4 and branch prediction with each one in a small circular FIFO. Presents the head entry to the IF/ID latch in the same field layout the latch consumes. Honours the latch's STALL (hold) and FLUSH (redirect) semantics, so fetch can run ahead of decode by up to DEPTH instructions.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
PTR_W, log2(DEPTH), localparam: pointer width
CNT_W, PTR_W+1, localparam: occupancy counter width

Ports:
CLK  input  1  clock, all state updates on posedge
RESET  input  1  asynchronous, active-low reset
FLUSH  input  1  synchronous clear, same signal driven to the IF/ID latch
STALL  input  1  downstream freeze, same signal driven to the IF/ID latch
Instr_Valid_IN  input  1  fetch unit presents a valid instruction this cycle
Instr_IN  input  32  fetched instruction word
Instr_PC_IN  input  32  address of the fetched instruction
Instr_PC_Plus4_IN  input  32  address of the next sequential instruction
Branch_prediction_IN  input  1  predicted-taken flag for this instruction
Queue_Full_OUT  output  1  count == DEPTH; fetch must not push unless a pop occurs
Instr_Valid_OUT  output  1  head entry valid (count != 0)
Instr1_OUT  output  32  head instruction word; 0 (NOP bubble) when empty
Instr_PC_OUT  output  32  head PC; 0 when empty
Instr_PC_Plus4_OUT  output  32  head PC+4; 0 when empty
Branch_prediction_OUT  output  1  head prediction; 0 when empty
Occupancy_OUT  output  CNT_W  current entry count

Behaviour:
- Storage: DEPTH entries of 97 bits {instr, pc, pc4, pred}. rd_ptr and wr_ptr are PTR_W bits wide and wrap naturally modulo DEPTH. count is CNT_W bits.
- pop = !STALL && count != 0. The head is consumed on the same posedge at which the IF/ID latch captures it.
- push = Instr_Valid_IN && (count < DEPTH || pop). If full with no simultaneous pop, the input is silently dropped and all state is unchanged.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at full and at count 1.
- Outputs are combinational from the head entry and count, with no internal register stage.
- When empty, all data outputs and Instr_Valid_OUT are 0.
- No bypass: an entry pushed into an empty queue appears on the outputs the cycle after the push edge. Minimum latency is 1 cycle from push to visibility, and the IF/ID latch captures it on the following edge.
- STALL=1: no pop; the head and all outputs hold stable; pushes continue until full.
- FLUSH=1 at posedge:
  - rd_ptr, wr_ptr and count go to 0.
  - Any push or pop requested that cycle is discarded.
  - FLUSH has priority over STALL, push and pop.
- RESET low (asynchronous, at any time including mid-drain):
  - rd_ptr, wr_ptr and count go to 0 immediately.
  - All outputs go to 0 and Queue_Full_OUT goes to 0.
  - Storage contents are don't-care.
  - Normal operation resumes at the first posedge after RESET deasserts.
- Queue_Full_OUT = (count == DEPTH). Instr_Valid_OUT = (count != 0).
- Occupancy never exceeds DEPTH and never underflows.

Test Plan:
1. RESET low for 2 cycles, then high -> count 0, every output 0, Queue_Full_OUT 0. Re-assert RESET with 3 entries queued -> outputs 0 immediately, without waiting for an edge.
2. STALL=0; push 0x20010001@0x00400000, 0x20020002@0x00400004, 0x20030003@0x00400008 on consecutive cycles -> outputs show each entry (PC+4 = 0x00400004/08/0C) one cycle after its push, in order; returns to all zeros after the third.
3. STALL=1 for 6 cycles while pushing 5 instructions, DEPTH=4 -> Queue_Full_OUT=1 after the 4th push; 5th dropped; head holds 0x00400000. Release STALL -> exactly 4 entries drain in order, then empty.
4. Queue full, STALL=0, push 0x00400010 in the same cycle -> count stays 4. Drain shows 0x00400004..0x00400010 in order.
5. 3 entries queued; FLUSH=1 with a push of 0x00400020 in the same cycle -> next cycle count 0, outputs 0; 0x00400020 never appears.
6. DEPTH=4, STALL=0, push 10 instructions back-to-back with PCs 0x00400000 + 4k -> pointers wrap twice; output sequence is exactly k=0..9; Branch_prediction_OUT matches the per-entry input pattern 1,0,1,...
